ram_to_file: RTL and testbench
==============================

// Module: ram_to_file
// PURPOSE
//  Memory read-back engine; the inverse of the boot loader that writes a program image into basic_ram.
//  - After the ARMv4 core stops, the bench or host muxes the RAM port over to this block.
//  - It reads WORD_COUNT 32-bit words starting at base_addr and streams them out on a valid/ready port.
//  - That stream goes to a dump/checker (file writer, comparator).
//  - Read data is buffered in a small FIFO, so sink backpressure never stalls a RAM access in flight.
// PARAMETERS
//  FIFO_DEPTH  4    read-data FIFO entries; power of 2, >= 2
//  TIMEOUT     255  max cycles to wait for mem_done per access before error
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous, active-low reset
//  start        in   1   1-cycle pulse: begin dump; ignored while busy=1
//  base_addr    in   32  first byte address; bits [1:0] ignored (forced 0)
//  word_count   in   16  words to read; sampled with start
//  busy         out  1   dump in progress (start accepted through last word drained)
//  done         out  1   1-cycle pulse when the last word leaves the FIFO, or on error
//  error        out  1   sticky timeout flag; cleared by the next accepted start
//  address      out  32  RAM address
//  data_input   out  32  RAM write data; always 0
//  data_output  in   32  RAM read data
//  cs           out  1   RAM chip select
//  we           out  1   RAM write enable; always 0
//  oe           out  1   RAM output enable
//  data_size    out  2   RAM access size; always 2'b11 (word)
//  mem_done     in   1   RAM access-complete strobe
//  dout         out  32  streamed word (FIFO head)
//  dout_addr    out  32  byte address the dout word was read from
//  dout_valid   out  1   dout/dout_addr valid
//  dout_ready   in   1   sink accepts when dout_valid & dout_ready
// BEHAVIOUR
//  Reset: outputs 0 except data_size=2'b11. FSM=IDLE, FIFO empty, counters 0.
//  FSM states:
//   IDLE  - wait for start.
//           On start: latch addr={base_addr[31:2],2'b00}, remaining=word_count, clear error.
//           word_count==0 -> DONE; else -> REQ.
//   REQ   - if FIFO has a free slot that counts words already in flight: assert cs=oe=1, drive address; -> WAIT.
//           else stay in REQ with cs=oe=0.
//   WAIT  - hold cs/oe/address stable; timer counts up.
//           mem_done=1 -> push {data_output,address} to FIFO, cs=oe=0 next cycle, addr+=4, remaining-=1.
//             remaining becomes 0 -> DRAIN; else -> REQ.
//           timer==TIMEOUT -> error=1, drop cs/oe, -> DRAIN.
//   DRAIN - wait for FIFO empty -> DONE.
//   DONE  - done=1 for one cycle, busy=0 -> IDLE.
//  Per-access cost: min 2 cycles (REQ+WAIT with mem_done on first WAIT cycle).
//   - cs is low for >=1 cycle between accesses, so the RAM sees a fresh edge.
//  busy is 1 from the cycle after start through DRAIN.
//  Address: increments by 4 and wraps 32'hFFFF_FFFC -> 0. No error on wrap.
//  FIFO: first-word-fall-through. dout_valid = !empty.
//   - Simultaneous push and pop when full is legal: the pop frees the slot in that same cycle.
//   - REQ never issues an access that would overflow the FIFO.
//  dout_ready with dout_valid=0 is ignored. dout is held stable while valid & !ready.
//  start while busy: ignored, no side effect.
//  Reset mid-dump: async rst_n low -> cs/oe drop immediately, FIFO flushed, IDLE.
//  Error: words already in the FIFO are still delivered, then done pulses; error stays 1 until the next start.
// TESTING
//  1. RAM preloaded 0x100..0x10C = A,B,C,D; base 0x100, count 4, dout_ready=1.
//     -> dout A,B,C,D with dout_addr 0x100,104,108,10C; one done pulse; error=0.
//  2. count 0 -> done within 2 cycles of start; cs never asserted; no dout_valid.
//  3. dout_ready=0 for 20 cycles, count 8, FIFO_DEPTH 4.
//     -> exactly 4 accesses issued then cs stays 0; after release all 8 words arrive in order.
//  4. RAM model never asserts mem_done.
//     -> error=1 after TIMEOUT+1 WAIT cycles; done pulses; next start clears error.
//  5. base 0xFFFFFFF8, count 3 -> dout_addr FFFFFFF8, FFFFFFFC, 00000000.
//  6. rst_n low while in WAIT with 2 words queued -> cs=oe=0 and dout_valid=0 same cycle; busy=0.
//     A new start then runs cleanly.

Source files
------------

// File: rtl/ram_to_file.sv
// Memory read-back engine: reads a block of words out of RAM and streams them with their
// byte addresses over a valid/ready port, buffering through a small first-word-fall-through FIFO.
module ram_to_file #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] base_addr,
   input  logic [15:0] word_count,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] address,
   output logic [31:0] data_input,
   input  logic [31:0] data_output,
   output logic        cs,
   output logic        we,
   output logic        oe,
   output logic [1:0]  data_size,
   input  logic        mem_done,
   output logic [31:0] dout,
   output logic [31:0] dout_addr,
   output logic        dout_valid,
   input  logic        dout_ready
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;

   state_t         state, state_next;
   logic [31:0]    addr_q;
   logic [15:0]    remaining;
   logic [TW-1:0]  timer;
   logic           error_q;

   logic [31:0]    fifo_data [FIFO_DEPTH];
   logic [31:0]    fifo_addr [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;

   logic push, pop, slot_free, timeout_hit, start_ok;

   // Only one access is ever in flight and it is pushed before REQ is re-entered,
   // so the occupancy alone tells REQ whether the next word has somewhere to go.
   assign push        = (state == WAIT) && mem_done;
   assign pop         = (count != '0) && dout_ready;
   assign slot_free   = count < CW'(FIFO_DEPTH);
   assign timeout_hit = timer == TW'(TIMEOUT);
   assign start_ok    = start && (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = (word_count == 16'd0) ? DONE : REQ;
         REQ:     if (slot_free) state_next = WAIT;
         WAIT: begin
            if (mem_done)         state_next = (remaining == 16'd1) ? DRAIN : REQ;
            else if (timeout_hit) state_next = DRAIN;
         end
         DRAIN:   if (count == '0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= '0;
         remaining <= '0;
         timer     <= '0;
         error_q   <= 1'b0;
      end else begin
         if (start_ok) begin
            addr_q    <= {base_addr[31:2], 2'b00};
            remaining <= word_count;
            error_q   <= 1'b0;
         end
         if (state == WAIT) begin
            if (mem_done) begin
               addr_q    <= addr_q + 32'd4;
               remaining <= remaining - 16'd1;
               timer     <= '0;
            end else if (timeout_hit) begin
               error_q <= 1'b1;
               timer   <= '0;
            end else begin
               timer <= timer + TW'(1);
            end
         end else begin
            timer <= '0;
         end
      end
   end

   // Storage needs no reset; occupancy and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= data_output;
         fifo_addr[wr_ptr] <= addr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign dout_valid = count != '0;
   assign dout       = dout_valid ? fifo_data[rd_ptr] : '0;
   assign dout_addr  = dout_valid ? fifo_addr[rd_ptr] : '0;

   // The RAM strobes are a pure decode of WAIT, so REQ leaves a cs-low gap between accesses.
   assign cs         = state == WAIT;
   assign oe         = state == WAIT;
   assign we         = 1'b0;
   assign address    = addr_q;
   assign data_input = '0;
   assign data_size  = 2'b11;
   assign busy       = (state == REQ) || (state == WAIT) || (state == DRAIN);
   assign done       = state == DONE;
   assign error      = error_q;

endmodule

// File: tb/tb_ram_to_file.sv
// Bench for ram_to_file: behavioural RAM with programmable latency, expected-word scoreboard,
// and directed scenarios for streaming, backpressure, timeout, address wrap and reset.
module tb_ram_to_file;

   localparam int TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] base_addr;
   logic [15:0] word_count;
   logic        busy, done, error;
   logic [31:0] address, data_input, data_output;
   logic        cs, we, oe;
   logic [1:0]  data_size;
   logic        mem_done;
   logic [31:0] dout, dout_addr;
   logic        dout_valid;
   logic        dout_ready;

   int checkCount = 0;
   int errorCount = 0;
   int doneCount = 0;
   int accessCount = 0;
   int latency = 0;
   bit noResponse = 1'b0;
   int readyMode = 1;
   logic [63:0] expectQ [$];
   bit          holdPrev = 1'b0;
   logic [31:0] holdData;
   logic [8:0]  waitCycles;

   ram_to_file #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .word_count(word_count),
      .busy(busy), .done(done), .error(error), .address(address), .data_input(data_input),
      .data_output(data_output), .cs(cs), .we(we), .oe(oe), .data_size(data_size),
      .mem_done(mem_done), .dout(dout), .dout_addr(dout_addr), .dout_valid(dout_valid),
      .dout_ready(dout_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ramWord(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
   endfunction

   // Behavioural RAM: answers an access after 'latency' cycles of cs, or never when noResponse.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) waitCycles <= '0;
      else if (cs && oe) begin
         if (waitCycles == 9'd0) accessCount <= accessCount + 1;
         waitCycles <= waitCycles + 9'd1;
      end else waitCycles <= '0;
   end

   assign mem_done    = cs && oe && !noResponse && (waitCycles == 9'(latency));
   assign data_output = ramWord(address);

   always @(posedge clk) begin
      #1;
      case (readyMode)
         0:       dout_ready = 1'b0;
         1:       dout_ready = 1'b1;
         default: dout_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Output monitor: scoreboard pop on each transfer, plus hold-stability under backpressure.
   always @(negedge clk) begin
      logic [63:0] exp;
      if (done) doneCount++;
      if (rst_n && dout_valid) begin
         if (holdPrev) checkOutput("hold_dout", {32'd0, dout}, {32'd0, holdData});
         if (dout_ready) begin
            holdPrev = 1'b0;
            if (expectQ.size() == 0) checkOutput("unexpected_word", 64'd1, 64'd0);
            else begin
               exp = expectQ.pop_front();
               checkOutput("dout", {32'd0, dout}, {32'd0, exp[31:0]});
               checkOutput("dout_addr", {32'd0, dout_addr}, {32'd0, exp[63:32]});
            end
         end else begin
            holdPrev = 1'b1;
            holdData = dout;
         end
      end else holdPrev = 1'b0;
   end

   task automatic applyStimulus(input logic [31:0] base, input logic [15:0] cnt, input bit expectWords);
      logic [31:0] a;
      a = {base[31:2], 2'b00};
      if (expectWords)
         for (int i = 0; i < int'(cnt); i++) begin
            expectQ.push_back({a, ramWord(a)});
            a = a + 32'd4;
         end
      @(posedge clk); #1;
      start = 1'b1; base_addr = base; word_count = cnt;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int limit, output int cycles);
      int d0;
      d0 = doneCount;
      cycles = 0;
      while (doneCount == d0 && cycles < limit) begin
         @(posedge clk); #2;
         cycles++;
      end
      checkOutput({tag, "_done_seen"}, 64'(doneCount != d0), 64'd1);
      repeat (3) @(posedge clk);
      #2;
      checkOutput({tag, "_one_done"}, 64'(doneCount - d0), 64'd1);
      checkOutput({tag, "_drained"}, 64'(expectQ.size()), 64'd0);
      checkOutput({tag, "_idle"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int cyc, base0, n;
      rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("reset_cs", {62'd0, cs, oe}, 64'd0);
      checkOutput("reset_flags", {61'd0, busy, done, error}, 64'd0);
      checkOutput("reset_valid", {63'd0, dout_valid}, 64'd0);
      checkOutput("reset_size", {62'd0, data_size}, 64'd3);
      @(negedge clk); rst_n = 1'b1;

      // Straight four-word dump, sink always ready
      latency = 0; readyMode = 1;
      applyStimulus(32'h100, 16'd4, 1'b1);
      checkOutput("t1_busy", {63'd0, busy}, 64'd1);
      waitDone("t1", 200, cyc);
      checkOutput("t1_error", {63'd0, error}, 64'd0);
      checkOutput("t1_static", {29'd0, we, data_input, 2'b00}, 64'd0);

      // Zero-length dump
      base0 = accessCount;
      applyStimulus(32'h200, 16'd0, 1'b0);
      waitDone("t2", 20, cyc);
      checkOutput("t2_latency", 64'(cyc <= 2), 64'd1);
      checkOutput("t2_no_access", 64'(accessCount - base0), 64'd0);

      // Backpressure: FIFO fills, then requests stop until the sink drains
      latency = 1; readyMode = 0;
      base0 = accessCount;
      applyStimulus(32'h400, 16'd8, 1'b1);
      repeat (20) @(posedge clk);
      #2;
      checkOutput("t3_accesses", 64'(accessCount - base0), 64'd4);
      checkOutput("t3_cs_low", {63'd0, cs}, 64'd0);
      readyMode = 1;
      waitDone("t3", 300, cyc);

      // Timeout: RAM never answers
      noResponse = 1'b1;
      applyStimulus(32'h800, 16'd2, 1'b0);
      n = 0;
      while (!cs && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (cs && n < 1000) begin n++; @(negedge clk); end
      checkOutput("t4_wait_len", 64'(n), 64'(TIMEOUT + 1));
      checkOutput("t4_error", {63'd0, error}, 64'd1);
      waitDone("t4", 50, cyc);
      checkOutput("t4_sticky", {63'd0, error}, 64'd1);
      noResponse = 1'b0;
      applyStimulus(32'h900, 16'd2, 1'b1);
      checkOutput("t4_cleared", {63'd0, error}, 64'd0);
      waitDone("t4b", 100, cyc);

      // Address wrap at the top of memory
      latency = 2;
      applyStimulus(32'hFFFF_FFF8, 16'd3, 1'b1);
      waitDone("t5", 100, cyc);

      // Random sink backpressure, unaligned base
      readyMode = 2; latency = 1;
      applyStimulus(32'h2003, 16'd12, 1'b1);
      waitDone("t5r", 500, cyc);

      // Reset mid-dump with two words queued and a third access in WAIT
      readyMode = 0; latency = 10;
      base0 = accessCount;
      applyStimulus(32'h3000, 16'd8, 1'b1);
      n = 0;
      while (!(accessCount - base0 == 3 && cs) && n < 200) begin @(negedge clk); n++; end
      checkOutput("t6_reached", 64'(n < 200), 64'd1);
      checkOutput("t6_queued", {63'd0, dout_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_cs", {62'd0, cs, oe}, 64'd0);
      checkOutput("t6_valid", {63'd0, dout_valid}, 64'd0);
      checkOutput("t6_busy", {63'd0, busy}, 64'd0);
      expectQ.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      readyMode = 1; latency = 0;
      applyStimulus(32'h3100, 16'd5, 1'b1);
      waitDone("t6", 100, cyc);
      checkOutput("t6_error", {63'd0, error}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
